// File: rtl/mem_pkg.sv
// Shared definitions for the byte-wide main memory and its requester.
// Holds the memory geometry defaults, the core request size codes, the
// requester FSM state type, and a helper that turns a size code into a
// beat count.
package mem_pkg;

  localparam int DEF_WORD_SIZE = 8;
  localparam int DEF_ADDR_W    = 16;
  localparam int DEF_MEM_LEN   = 65000;
  localparam int DEF_MAX_BEATS = 4;

  // Core request size codes (code 3 is illegal)
  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  // Beats for a size code. Four bits so the illegal code 3 yields 8
  // instead of wrapping to 0.
  function automatic logic [3:0] size_beats(input logic [1:0] sz);
    return 4'd1 << sz;
  endfunction

endpackage

// File: rtl/mem_word_requester.sv
// Requester-side controller for the byte-wide main memory.
// Accepts 8/16/32-bit loads/stores over valid/ready, walks the memory one
// byte per cycle (little-endian), and returns a response over valid/ready.
// Out-of-range or illegal-size requests get an immediate error response
// without touching memory.
//
// Ports
//   clk, reset                 clock; synchronous active-high reset
//   req_valid/req_ready        request handshake (ready only while idle)
//   req_write, req_size        1=store; 0/1/2 = 1/2/4 beats, 3 illegal
//   req_addr, req_wdata        base byte address, store data (byte 0 in LSBs)
//   resp_valid/resp_ready      response handshake
//   resp_rdata, resp_err       load data (zero-extended), reject flag
//   mem_addr, mem_wdata,       memory address, write byte, write enable
//   mem_we, mem_rdata          and async read data
module mem_word_requester
  import mem_pkg::*;
#(
  parameter int WORD_SIZE = DEF_WORD_SIZE,
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int MEM_LEN   = DEF_MEM_LEN,
  parameter int MAX_BEATS = DEF_MAX_BEATS
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           req_valid,
  output logic                           req_ready,
  input  logic                           req_write,
  input  logic [1:0]                     req_size,
  input  logic [ADDR_W-1:0]              req_addr,
  input  logic [MAX_BEATS*WORD_SIZE-1:0] req_wdata,
  output logic                           resp_valid,
  input  logic                           resp_ready,
  output logic [MAX_BEATS*WORD_SIZE-1:0] resp_rdata,
  output logic                           resp_err,
  output logic [ADDR_W-1:0]              mem_addr,
  output logic [WORD_SIZE-1:0]           mem_wdata,
  output logic                           mem_we,
  input  logic [WORD_SIZE-1:0]           mem_rdata
);

  localparam int DW = MAX_BEATS * WORD_SIZE;
  localparam int BW = (MAX_BEATS > 1) ? $clog2(MAX_BEATS) : 1;

  state_t            state;
  logic              write_q;
  logic              err_q;
  logic [BW-1:0]     beat;
  logic [BW-1:0]     last_beat;
  logic [ADDR_W-1:0] base;
  logic [DW-1:0]     wdata_q;
  logic [DW-1:0]     rdata_q;

  logic              in_access;
  logic [ADDR_W:0]   end_addr;
  logic              req_bad;

  // One extra bit so the end address of a request near the top of the
  // address space cannot wrap back into range.
  assign end_addr = {1'b0, req_addr}
                  + (ADDR_W+1)'(size_beats(req_size))
                  - (ADDR_W+1)'(1);
  assign req_bad  = (req_size == 2'd3) || (end_addr >= (ADDR_W+1)'(MEM_LEN));

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      write_q   <= 1'b0;
      err_q     <= 1'b0;
      beat      <= '0;
      last_beat <= '0;
      base      <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            write_q   <= req_write;
            base      <= req_addr;
            wdata_q   <= req_wdata;
            last_beat <= BW'(size_beats(req_size) - 4'd1);
            beat      <= '0;
            rdata_q   <= '0;
            err_q     <= req_bad;
            state     <= req_bad ? RESP : ACCESS;
          end
        end
        ACCESS: begin
          if (!write_q)
            rdata_q[beat*WORD_SIZE +: WORD_SIZE] <= mem_rdata;
          if (beat == last_beat) state <= RESP;
          else                   beat  <= beat + 1'b1;
        end
        RESP: begin
          if (resp_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign in_access  = (state == ACCESS);
  assign req_ready  = (state == IDLE);
  assign resp_valid = (state == RESP);
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;

  assign mem_addr   = in_access ? base + ADDR_W'(beat) : '0;
  assign mem_wdata  = in_access ? wdata_q[beat*WORD_SIZE +: WORD_SIZE] : '0;
  // Gated by reset so a beat in flight when reset arrives is not written.
  assign mem_we     = in_access && write_q && !reset;

endmodule

// File: tb/tb_mem_word_requester.sv
module tb_mem_word_requester;
  import mem_pkg::*;

  localparam int ML = 65000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0, req_write = 1'b0, resp_ready = 1'b1;
  logic [1:0]  req_size = 2'd0;
  logic [15:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        req_ready, resp_valid, resp_err, mem_we;
  logic [31:0] resp_rdata;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata, mem_rdata;

  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  mem_word_requester dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_size(req_size), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
    .mem_rdata(mem_rdata)
  );

  // Main memory: async read, sync write
  logic [7:0] mem [0:ML-1];
  assign mem_rdata = (int'(mem_addr) < ML) ? mem[mem_addr] : 8'h00;
  always @(posedge clk)
    if (mem_we && int'(mem_addr) < ML) mem[mem_addr] <= mem_wdata;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h at %0t", nm, got, exp, $time);
    end
  endtask

  // Reference model: one outstanding transaction, timed from its accept.
  // m_k counts cycles since accept (1 = first cycle after accept).
  logic [7:0]  ref_mem [0:ML-1];
  bit          m_busy = 0, m_write = 0, m_err = 0;
  int          m_k = 0, m_n = 1, m_rk = 1, m_base = 0;
  logic [31:0] m_wdata = '0, m_exp = '0;

  always @(posedge clk) begin
    if (reset) m_busy = 0;
    else if (m_busy) begin
      if (m_k >= m_rk && resp_ready) m_busy = 0;
      else begin
        if (!m_err && m_write && m_k >= 1 && m_k <= m_n)
          ref_mem[m_base + m_k - 1] = m_wdata[8*(m_k-1) +: 8];
        m_k++;
      end
    end else if (req_valid) begin
      m_busy  = 1;
      m_write = req_write;
      m_base  = int'(req_addr);
      m_wdata = req_wdata;
      m_n     = 1 << req_size;
      m_err   = (req_size == 2'd3) || (m_base + m_n - 1 >= ML);
      m_rk    = m_err ? 1 : m_n + 1;
      m_k     = 1;
      m_exp   = '0;
      if (!m_err && !m_write)
        for (int i = 0; i < m_n; i++) m_exp[8*i +: 8] = ref_mem[m_base + i];
    end
  end

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    bit in_resp, in_beat;
    if (reset) chk("we_in_reset", mem_we, 0);
    else begin
      in_resp = m_busy && m_k >= m_rk;
      in_beat = m_busy && !m_err && m_k >= 1 && m_k <= m_n;
      chk("req_ready", req_ready, !m_busy);
      chk("resp_valid", resp_valid, in_resp);
      chk("mem_we", mem_we, in_beat && m_write);
      if (in_beat) begin
        chk("mem_addr", mem_addr, m_base + m_k - 1);
        if (m_write) chk("mem_wdata", mem_wdata, m_wdata[8*(m_k-1) +: 8]);
      end
      if (in_resp) begin
        chk("resp_err", resp_err, m_err);
        chk("resp_rdata", resp_rdata, m_exp);
      end
    end
  end

  // Issue one request from #1 after a posedge; returns #1 after the
  // handshake edge. lat = cycles from accept to first resp_valid.
  task automatic run_req(input bit wr, input logic [1:0] sz, input logic [15:0] addr,
                         input logic [31:0] wd, input bit rand_rdy,
                         output logic [31:0] rd, output bit er, output int lat);
    int t;
    bit hs;
    rd = '0; er = 0; lat = 0;
    req_write = wr; req_size = sz; req_addr = addr; req_wdata = wd; req_valid = 1;
    t = 0;
    while (!req_ready && t < 200) begin @(posedge clk); #1; t++; end
    if (t >= 200) begin chk("accept_timeout", 1, 0); req_valid = 0; return; end
    @(posedge clk); #1;
    req_valid = 0;
    lat = 1; t = 0;
    while (!resp_valid && t < 200) begin @(posedge clk); #1; lat++; t++; end
    if (t >= 200) begin chk("resp_timeout", 1, 0); return; end
    t = 0;
    do begin
      resp_ready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
      rd = resp_rdata; er = resp_err;
      hs = resp_valid && resp_ready;
      @(posedge clk); #1;
      t++;
    end while (!hs && t < 200);
    if (!hs) chk("handshake_timeout", 1, 0);
    resp_ready = 1;
  endtask

  initial begin
    logic [31:0] rd, hold;
    bit er;
    int lat, t;

    for (int i = 0; i < ML; i++) begin mem[i] = 8'h00; ref_mem[i] = 8'h00; end
    reset = 1;
    repeat (3) @(posedge clk);
    #1 reset = 0;
    chk("rst_req_ready", req_ready, 1);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_resp_err", resp_err, 0);
    chk("rst_resp_rdata", resp_rdata, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_addr", mem_addr, 0);

    // 1: word store
    run_req(1, SZ_W, 16'h0010, 32'hDEADBEEF, 0, rd, er, lat);
    chk("st_lat", lat, 5); chk("st_err", er, 0); chk("st_rdata", rd, 0);
    chk("mem10", mem[16'h10], 8'hEF); chk("mem11", mem[16'h11], 8'hBE);
    chk("mem12", mem[16'h12], 8'hAD); chk("mem13", mem[16'h13], 8'hDE);

    // 2: loads
    run_req(0, SZ_W, 16'h0010, 0, 0, rd, er, lat);
    chk("ldw_data", rd, 32'hDEADBEEF); chk("ldw_lat", lat, 5);
    run_req(0, SZ_B, 16'h0012, 0, 0, rd, er, lat);
    chk("ldb_data", rd, 32'h000000AD); chk("ldb_lat", lat, 2);
    run_req(0, SZ_H, 16'h0011, 0, 0, rd, er, lat);
    chk("ldh_data", rd, 32'h0000ADBE); chk("ldh_lat", lat, 3);

    // 3: boundaries (locations 0..64999 valid)
    run_req(1, SZ_B, 16'd64999, 32'h0000005A, 0, rd, er, lat);
    chk("st_last_err", er, 0); chk("mem_last", mem[64999], 8'h5A);
    run_req(0, SZ_W, 16'd64996, 0, 0, rd, er, lat);
    chk("ld_top_err", er, 0); chk("ld_top_data", rd, 32'h5A000000);
    run_req(0, SZ_W, 16'd64997, 0, 0, rd, er, lat);
    chk("ld_over_err", er, 1); chk("ld_over_lat", lat, 1);
    run_req(1, SZ_W, 16'd64998, 32'h11111111, 0, rd, er, lat);
    chk("st_over_err", er, 1); chk("st_over_lat", lat, 1); chk("st_over_rdata", rd, 0);
    chk("st_over_mem", mem[64998], 8'h00);
    run_req(0, 2'd3, 16'h0000, 0, 0, rd, er, lat);
    chk("sz3_err", er, 1); chk("sz3_lat", lat, 1);
    run_req(0, SZ_H, 16'd65535, 0, 0, rd, er, lat);
    chk("wrap_err", er, 1);

    // 4: backpressure, then a pending request waiting for the handshake
    resp_ready = 0;
    req_write = 0; req_size = SZ_W; req_addr = 16'h0010; req_valid = 1;
    @(posedge clk); #1;
    req_write = 1; req_size = SZ_B; req_addr = 16'h0030; req_wdata = 32'h000000C3;
    t = 0;
    while (!resp_valid && t < 20) begin @(posedge clk); #1; t++; end
    chk("hold_rdata0", resp_rdata, 32'hDEADBEEF);
    hold = resp_rdata;
    repeat (10) begin
      @(posedge clk); #1;
      chk("hold_valid", resp_valid, 1);
      chk("hold_rdata", resp_rdata, hold);
      chk("hold_ready", req_ready, 0);
    end
    resp_ready = 1;
    @(posedge clk); #1;
    chk("after_hs_valid", resp_valid, 0);
    chk("after_hs_ready", req_ready, 1);
    @(posedge clk); #1;
    req_valid = 0;
    chk("second_accepted", req_ready, 0);
    t = 0;
    while (!req_ready && t < 20) begin @(posedge clk); #1; t++; end
    chk("second_mem", mem[16'h30], 8'hC3);

    // 5: reset during beat 2 of a word store
    run_req(1, SZ_W, 16'h0100, 32'hAAAAAAAA, 0, rd, er, lat);
    req_write = 1; req_size = SZ_W; req_addr = 16'h0100; req_wdata = 32'h44332211; req_valid = 1;
    @(posedge clk); #1;
    req_valid = 0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1;
    @(posedge clk); #1;
    reset = 0;
    chk("abort_ready", req_ready, 1);
    chk("abort_valid", resp_valid, 0);
    chk("abort_we", mem_we, 0);
    chk("abort_b0", mem[16'h100], 8'h11); chk("abort_b1", mem[16'h101], 8'h22);
    chk("abort_b2", mem[16'h102], 8'hAA); chk("abort_b3", mem[16'h103], 8'hAA);
    @(posedge clk); #1;

    // 6: mixed stream with random backpressure
    for (int i = 0; i < 60; i++) begin
      logic [15:0] a;
      a = ($urandom_range(0, 7) == 0) ? 16'(64990 + $urandom_range(0, 15))
                                      : 16'(32 + $urandom_range(0, 31));
      run_req(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), a, $urandom, 1, rd, er, lat);
    end

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
